cpu_control_fsm: RTL and testbench

//  Multicycle control unit that drives the ALU: decodes the 32-bit instruction and issues alu_sel

---
 rtl/cpu_defs_pkg.sv | 73 +++++++
 rtl/alu_decoder.sv | 66 ++++++
 rtl/cpu_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle control unit: opcode/func encodings, ALU select codes,
// FSM state encoding, instruction classes and the decoded-instruction bundle.
package cpu_defs_pkg;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;

  // R-type func[5:4] must carry this prefix
  localparam logic [1:0] FUNC_PREFIX = 2'b11;

  // ALU operation encoding
  localparam logic [3:0] ALU_SEL_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SEL_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SEL_AND   = 4'b0010;
  localparam logic [3:0] ALU_SEL_OR    = 4'b0011;
  localparam logic [3:0] ALU_SEL_NOT   = 4'b0100;
  localparam logic [3:0] ALU_SEL_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SEL_SHL   = 4'b1001;
  localparam logic [3:0] ALU_SEL_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SEL_ROL   = 4'b1100;
  localparam logic [3:0] ALU_SEL_ROR   = 4'b1101;
  localparam logic [3:0] ALU_SEL_PASSB = 4'b1111;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBr,
    ClsBeq,
    ClsBne
  } instr_cls_e;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       alu_src_b;
    logic       imm_zext;
    instr_cls_e cls;
    logic       illegal;
  } dec_t;

  // PASSB is reachable only through li, so an R-type func selecting it is illegal.
  function automatic logic rtype_func_ok(logic [5:0] func);
    logic ok;
    ok = 1'b0;
    if (func[5:4] == FUNC_PREFIX) begin
      case (func[3:0])
        ALU_SEL_ADD, ALU_SEL_SUB, ALU_SEL_AND, ALU_SEL_OR, ALU_SEL_NOT,
        ALU_SEL_SRA, ALU_SEL_SHL, ALU_SEL_SRL, ALU_SEL_ROL, ALU_SEL_ROR: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder.
// Ports:
//   op_i   - opcode field instr[31:26]
//   func_i - R-type function field instr[5:0]
//   dec_o  - ALU select, operand-B source, immediate extension, instruction class, illegal flag
module alu_decoder
  import cpu_defs_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.cls = ClsAlu;
    unique case (op_i)
      OP_RTYPE: begin
        dec_o.alu_sel = func_i[3:0];
        dec_o.illegal = ~rtype_func_ok(func_i);
      end
      OP_LI: begin
        dec_o.alu_sel   = ALU_SEL_PASSB;
        dec_o.alu_src_b = 1'b1;
      end
      OP_ADDI: begin
        dec_o.alu_sel   = ALU_SEL_ADD;
        dec_o.alu_src_b = 1'b1;
      end
      OP_ANDI: begin
        dec_o.alu_sel   = ALU_SEL_AND;
        dec_o.alu_src_b = 1'b1;
        dec_o.imm_zext  = 1'b1;
      end
      OP_ORI: begin
        dec_o.alu_sel   = ALU_SEL_OR;
        dec_o.alu_src_b = 1'b1;
        dec_o.imm_zext  = 1'b1;
      end
      OP_LW: begin
        dec_o.alu_sel   = ALU_SEL_ADD;
        dec_o.alu_src_b = 1'b1;
        dec_o.cls       = ClsLoad;
      end
      OP_SW: begin
        dec_o.alu_sel   = ALU_SEL_ADD;
        dec_o.alu_src_b = 1'b1;
        dec_o.cls       = ClsStore;
      end
      OP_B: begin
        // ALU result is unused by an unconditional branch
        dec_o.cls = ClsBr;
      end
      OP_BEQ: begin
        dec_o.alu_sel = ALU_SEL_SUB;
        dec_o.cls     = ClsBeq;
      end
      OP_BNE: begin
        dec_o.alu_sel = ALU_SEL_SUB;
        dec_o.cls     = ClsBne;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the ALU select and
// datapath strobes, handles the memory handshake with a wait-cycle timeout, and traps on
// illegal instructions or memory timeout.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   instr               - instruction register contents
//   alu_zero            - ALU zero flag (used by conditional branches in EXEC)
//   mem_ack             - memory completes the current request
//   mem_req, mem_we     - memory request / write qualifier
//   ir_we, pc_we        - IR load and PC update strobes
//   pc_src              - 0: PC+4, 1: branch target
//   alu_sel, alu_src_b  - ALU operation and operand-B source
//   imm_zext            - immediate zero-extend (1) or sign-extend (0)
//   rf_we, rf_wsel      - register-file write strobe and write-data select
//   trap                - sticky illegal-instruction / timeout flag
module cpu_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [3:0]  alu_sel,
  output logic        alu_src_b,
  output logic        imm_zext,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic        trap
);

  localparam logic [7:0] WaitLast = 8'(WAIT_LIMIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       quiet_q;
  dec_t       dec_q, dec_d;
  dec_t       dec_now;

  logic mem_busy;
  logic mem_wait;
  logic mem_done;
  logic strobe_ok;
  logic unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  alu_decoder u_alu_decoder (
    .op_i   (instr[31:26]),
    .func_i (instr[5:0]),
    .dec_o  (dec_now)
  );

  // quiet_q holds every output low for the first cycle after reset, so a reset issued
  // mid-transfer drops mem_req on the following cycle and any ack there is ignored.
  assign mem_busy  = ~quiet_q & ((state_q == StFetch) | (state_q == StMem));
  assign mem_wait  = mem_busy & ~mem_ack;
  assign mem_done  = mem_busy & mem_ack;
  // A reset in the current cycle suppresses write strobes so nothing commits.
  assign strobe_ok = ~rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      quiet_q    <= 1'b1;
      dec_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      quiet_q    <= 1'b0;
      dec_q      <= dec_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    // Latch the decode in DECODE so EXEC..WB stay stable regardless of instr.
    dec_d   = (state_q == StDecode) ? dec_now : dec_q;

    unique case (state_q)
      StFetch: begin
        if (mem_done) state_d = StDecode;
      end
      StDecode: begin
        state_d = dec_now.illegal ? StTrap : StExec;
      end
      StExec: begin
        case (dec_q.cls)
          ClsAlu:             state_d = StWb;
          ClsLoad, ClsStore:  state_d = StMem;
          default:            state_d = StFetch;
        endcase
      end
      StMem: begin
        if (mem_done) state_d = (dec_q.cls == ClsLoad) ? StWb : StFetch;
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase

    // This cycle would be the WAIT_LIMIT-th un-acked cycle.
    if (mem_wait && (wait_cnt_q == WaitLast)) state_d = StTrap;

    wait_cnt_d = (mem_wait && (state_d == state_q)) ? wait_cnt_q + 8'd1 : '0;
  end

  // Output logic
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_sel   = ALU_SEL_ADD;
    alu_src_b = 1'b0;
    imm_zext  = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    trap      = 1'b0;

    if (!quiet_q) begin
      if ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) begin
        alu_sel   = dec_q.alu_sel;
        alu_src_b = dec_q.alu_src_b;
        imm_zext  = dec_q.imm_zext;
      end

      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          ir_we   = mem_ack & strobe_ok;
          pc_we   = mem_ack & strobe_ok;
        end
        StExec: begin
          case (dec_q.cls)
            ClsBr: begin
              pc_src = 1'b1;
              pc_we  = strobe_ok;
            end
            ClsBeq: begin
              pc_src = 1'b1;
              pc_we  = alu_zero & strobe_ok;
            end
            ClsBne: begin
              pc_src = 1'b1;
              pc_we  = ~alu_zero & strobe_ok;
            end
            default: ;
          endcase
        end
        StMem: begin
          mem_req = 1'b1;
          mem_we  = (dec_q.cls == ClsStore);
        end
        StWb: begin
          rf_we   = strobe_ok;
          rf_wsel = (dec_q.cls == ClsLoad);
        end
        StTrap:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus pushes the hand-computed output vector for
// each driven cycle; a monitor pops and compares it on the falling edge of that cycle.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, pc_src;
  logic [3:0]  alu_sel;
  logic        alu_src_b, imm_zext, rf_we, rf_wsel, trap;

  always #5 clk = ~clk;

  cpu_control_fsm #(
    .WAIT_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_sel   (alu_sel),
    .alu_src_b (alu_src_b),
    .imm_zext  (imm_zext),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .trap      (trap)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [3:0] alu_sel;
    logic       alu_src_b;
    logic       imm_zext;
    logic       rf_we;
    logic       rf_wsel;
    logic       trap;
  } out_t;

  typedef struct {
    out_t  v;
    string name;
  } exp_t;

  localparam out_t Zero = '0;

  exp_t exp_q[$];
  exp_t mon_e;
  out_t obs;
  int   checks = 0;
  int   errors = 0;

  assign obs = {mem_req, mem_we, ir_we, pc_we, pc_src, alu_sel, alu_src_b, imm_zext,
                rf_we, rf_wsel, trap};

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (obs !== mon_e.v) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b (req,we,ir,pc,src,sel4,srcb,zext,rf,wsel,trap)",
                 mon_e.name, obs, mon_e.v);
      end
    end
  end

  function automatic out_t o_fetch(input logic ack);
    out_t o;
    o         = '0;
    o.mem_req = 1'b1;
    o.ir_we   = ack;
    o.pc_we   = ack;
    return o;
  endfunction

  function automatic out_t o_dec(input logic [3:0] s, input logic sb, input logic zx);
    out_t o;
    o           = '0;
    o.alu_sel   = s;
    o.alu_src_b = sb;
    o.imm_zext  = zx;
    return o;
  endfunction

  function automatic out_t o_trap();
    out_t o;
    o      = '0;
    o.trap = 1'b1;
    return o;
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, input logic z, input logic ack,
                      input logic chk, input out_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst      = r;
    instr    = ins;
    alu_zero = z;
    mem_ack  = ack;
    if (chk) begin
      x.v    = e;
      x.name = nm;
      exp_q.push_back(x);
    end
  endtask

  // Reset cycle, then the quiet cycle with a stray ack that must be ignored.
  task automatic do_reset(input string nm);
    step(1'b1, '0, 1'b0, 1'b1, 1'b0, Zero, nm);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, Zero, {nm, "_quiet"});
  endtask

  task automatic run_alu(input logic [31:0] ins, input logic [3:0] s, input logic sb,
                         input logic zx, input string nm);
    out_t e;
    step(1'b0, ins, 1'b0, 1'b1, 1'b1, o_fetch(1'b1), {nm, "_fetch"});
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, Zero, {nm, "_decode"});
    e = o_dec(s, sb, zx);
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, e, {nm, "_exec"});
    e.rf_we = 1'b1;
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, e, {nm, "_wb"});
  endtask

  task automatic run_branch(input logic [31:0] ins, input logic z, input logic take,
                            input string nm);
    out_t e;
    step(1'b0, ins, 1'b0, 1'b1, 1'b1, o_fetch(1'b1), {nm, "_fetch"});
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, Zero, {nm, "_decode"});
    e        = o_dec(4'b0001, 1'b0, 1'b0);
    e.pc_src = 1'b1;
    e.pc_we  = take;
    step(1'b0, ins, z, 1'b0, 1'b1, e, {nm, "_exec"});
  endtask

  task automatic run_mem(input logic [31:0] ins, input logic store, input int waits,
                         input string nm);
    out_t e;
    step(1'b0, ins, 1'b0, 1'b1, 1'b1, o_fetch(1'b1), {nm, "_fetch"});
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, Zero, {nm, "_decode"});
    e = o_dec(4'b0000, 1'b1, 1'b0);
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, e, {nm, "_exec"});
    e.mem_req = 1'b1;
    e.mem_we  = store;
    for (int i = 0; i < waits; i++) step(1'b0, ins, 1'b0, 1'b0, 1'b1, e, {nm, "_mem_wait"});
    step(1'b0, ins, 1'b0, 1'b1, 1'b1, e, {nm, "_mem_ack"});
    if (!store) begin
      e         = o_dec(4'b0000, 1'b1, 1'b0);
      e.rf_we   = 1'b1;
      e.rf_wsel = 1'b1;
      step(1'b0, ins, 1'b0, 1'b0, 1'b1, e, {nm, "_wb"});
    end
  endtask

  task automatic run_illegal(input logic [31:0] ins, input string nm);
    step(1'b0, ins, 1'b0, 1'b1, 1'b1, o_fetch(1'b1), {nm, "_fetch"});
    step(1'b0, ins, 1'b0, 1'b0, 1'b1, Zero, {nm, "_decode"});
    step(1'b0, ins, 1'b0, 1'b1, 1'b1, o_trap(), {nm, "_trap"});
    step(1'b0, ins, 1'b1, 1'b1, 1'b1, o_trap(), {nm, "_trap_hold"});
  endtask

  initial begin
    logic [31:0] i_addi, i_shl, i_andi, i_beq, i_bne, i_sw, i_lw, i_badf, i_passb, i_badop;
    out_t        e;
    i_addi  = {6'b110000, 5'd0, 5'd1, 16'd5};
    i_shl   = {6'b100000, 20'd0, 6'b111001};
    i_andi  = {6'b110010, 10'd0, 16'h00f0};
    i_beq   = {6'b010000, 10'd0, 16'hfffe};
    i_bne   = {6'b010001, 10'd0, 16'h0004};
    i_sw    = {6'b000111, 10'd0, 16'd8};
    i_lw    = {6'b000011, 10'd0, 16'd12};
    i_badf  = {6'b100000, 20'd0, 6'b110111};
    i_passb = {6'b100000, 20'd0, 6'b111111};
    i_badop = {6'b101010, 26'd0};

    do_reset("reset");
    run_alu(i_addi, 4'b0000, 1'b1, 1'b0, "addi");
    run_alu(i_shl, 4'b1001, 1'b0, 1'b0, "shl");
    run_alu(i_andi, 4'b0010, 1'b1, 1'b1, "andi");
    run_branch(i_beq, 1'b1, 1'b1, "beq_taken");
    run_branch(i_beq, 1'b0, 1'b0, "beq_not_taken");
    run_branch(i_bne, 1'b0, 1'b1, "bne_taken");
    run_branch(i_bne, 1'b1, 1'b0, "bne_not_taken");
    // sw with ack on the 4th MEM cycle: three waits stay below the limit of 4
    run_mem(i_sw, 1'b1, 3, "sw");
    e         = '0;
    e.mem_req = 1'b1;
    step(1'b0, i_sw, 1'b0, 1'b0, 1'b1, e, "sw_then_fetch");
    run_mem(i_lw, 1'b0, 0, "lw");
    run_illegal(i_badf, "rtype_bad_func");

    // Trap must hold through further cycles until reset
    do_reset("reset2");
    run_illegal(i_passb, "rtype_passb");
    do_reset("reset3");
    run_illegal(i_badop, "bad_opcode");

    // Fetch timeout: four un-acked cycles, then trap
    do_reset("reset4");
    for (int i = 0; i < 4; i++) step(1'b0, i_addi, 1'b0, 1'b0, 1'b1, o_fetch(1'b0), "to_wait");
    step(1'b0, i_addi, 1'b0, 1'b0, 1'b1, o_trap(), "to_trap");
    step(1'b0, i_addi, 1'b0, 1'b1, 1'b1, o_trap(), "to_trap_hold");
    step(1'b0, i_addi, 1'b0, 1'b0, 1'b1, o_trap(), "to_trap_hold2");

    // Reset during MEM of lw: rst wins over a simultaneous ack, no rf_we follows
    do_reset("reset5");
    step(1'b0, i_lw, 1'b0, 1'b1, 1'b1, o_fetch(1'b1), "abort_fetch");
    step(1'b0, i_lw, 1'b0, 1'b0, 1'b1, Zero, "abort_decode");
    e = o_dec(4'b0000, 1'b1, 1'b0);
    step(1'b0, i_lw, 1'b0, 1'b0, 1'b1, e, "abort_exec");
    e.mem_req = 1'b1;
    step(1'b0, i_lw, 1'b0, 1'b0, 1'b1, e, "abort_mem_wait");
    step(1'b1, i_lw, 1'b0, 1'b1, 1'b1, e, "abort_mem_rst");
    step(1'b0, i_lw, 1'b0, 1'b0, 1'b1, Zero, "abort_quiet");
    step(1'b0, i_lw, 1'b0, 1'b0, 1'b1, o_fetch(1'b0), "abort_refetch");
    step(1'b0, i_lw, 1'b0, 1'b1, 1'b1, o_fetch(1'b1), "abort_refetch_ack");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
